serial_out_stage_p: RTL and testbench

Parametrised successor to the 8-channel serial output stage. Takes a framed parallel word, a one-hot channel select and a bit count through a valid/ready handshake. Serialises the word onto the selected channel's data/valid pair. Adds a one-entry pending buffer for zero-gap back-to-back frames, selectable bit order, frame validation, abort and a frame-done pulse. Sits between the Gray-coding stage and the chip pads; crc_valid feeds the downstream CRC unit.

---
 rtl/serial_out_stage_p.sv | 153 +++++++++++++++
 tb/tb_serial_out_stage_p.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_out_stage_p.sv
// Parametrised serial output stage: framed parallel word in through valid/ready,
// serialised onto one selected channel, with a one-entry pending buffer for gapless frames.
module serial_out_stage_p #(
  parameter int NUM_CH    = 8,
  parameter int DATA_W    = 128,
  parameter int CNT_W     = 16,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk_out16x,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] data_gray,
  input  logic [NUM_CH-1:0] vld_ch,
  input  logic [CNT_W-1:0]  data_count,
  input  logic              abort,
  output logic [NUM_CH-1:0] data_out,
  output logic [NUM_CH-1:0] data_vld,
  output logic              crc_valid,
  output logic              busy,
  output logic              frame_done,
  output logic              err_frame
);

  typedef enum logic {S_IDLE = 1'b0, S_SEND = 1'b1} state_t;

  function automatic logic is_onehot(input logic [NUM_CH-1:0] v);
    return (v != {NUM_CH{1'b0}}) && ((v & (v - NUM_CH'(1))) == {NUM_CH{1'b0}});
  endfunction

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_pend_full;
  logic [DATA_W-1:0]   r_pend_data;
  logic [NUM_CH-1:0]   r_pend_ch;
  logic [CNT_W-1:0]    r_pend_len;
  logic [DATA_W-1:0]   r_shift;
  logic [NUM_CH-1:0]   r_ch;
  logic [CNT_W-1:0]    r_len;
  logic [CNT_W-1:0]    r_bit_cnt;
  logic                r_frame_done;
  logic                r_err_frame;

  logic                w_accept;
  logic                w_frame_ok;
  logic [CNT_W-1:0]    w_len_clamped;
  logic                w_last;
  logic                w_load;
  logic                w_bit;

  assign w_accept      = in_valid && in_ready;
  assign w_frame_ok    = is_onehot(vld_ch) && (data_count != {CNT_W{1'b0}});
  assign w_len_clamped = (data_count > CNT_W'(DATA_W)) ? CNT_W'(DATA_W) : data_count;
  assign w_last        = (r_state == S_SEND) && (r_bit_cnt == (r_len - CNT_W'(1)));
  // Pending frame moves to the shifter when idle or on the last bit, so frames abut
  assign w_load        = r_pend_full && ((r_state == S_IDLE) || w_last);
  assign w_bit         = MSB_FIRST ? r_shift[DATA_W-1] : r_shift[0];

  assign in_ready   = !r_pend_full;
  assign busy       = (r_state == S_SEND) || r_pend_full;
  assign frame_done = r_frame_done;
  assign err_frame  = r_err_frame;

  always_ff @(posedge clk_out16x or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  w_state_nxt = r_pend_full ? S_SEND : S_IDLE;
        S_SEND:  w_state_nxt = (w_last && !r_pend_full) ? S_IDLE : S_SEND;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    data_vld = {NUM_CH{1'b0}};
    data_out = {NUM_CH{1'b0}};
    case (r_state)
      S_SEND: begin
        data_vld = r_ch;
        data_out = r_ch & {NUM_CH{w_bit}};
      end
      S_IDLE: begin
        data_vld = {NUM_CH{1'b0}};
        data_out = {NUM_CH{1'b0}};
      end
      default: begin
        data_vld = {NUM_CH{1'b0}};
        data_out = {NUM_CH{1'b0}};
      end
    endcase
  end

  assign crc_valid = |data_vld;

  always_ff @(posedge clk_out16x or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_full  <= 1'b0;
      r_pend_data  <= {DATA_W{1'b0}};
      r_pend_ch    <= {NUM_CH{1'b0}};
      r_pend_len   <= {CNT_W{1'b0}};
      r_frame_done <= 1'b0;
      r_err_frame  <= 1'b0;
    end else if (abort) begin
      r_pend_full  <= 1'b0;
      r_frame_done <= 1'b0;
      r_err_frame  <= 1'b0;
    end else begin
      r_frame_done <= w_last;
      r_err_frame  <= w_accept && !w_frame_ok;
      if (w_accept && w_frame_ok) begin
        r_pend_full <= 1'b1;
        r_pend_data <= data_gray;
        r_pend_ch   <= vld_ch;
        r_pend_len  <= w_len_clamped;
      end else if (w_load) begin
        r_pend_full <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_out16x or negedge rst_n) begin
    if (!rst_n) begin
      r_shift   <= {DATA_W{1'b0}};
      r_ch      <= {NUM_CH{1'b0}};
      r_len     <= {CNT_W{1'b0}};
      r_bit_cnt <= {CNT_W{1'b0}};
    end else if (abort) begin
      r_bit_cnt <= {CNT_W{1'b0}};
    end else if (w_load) begin
      r_shift   <= r_pend_data;
      r_ch      <= r_pend_ch;
      r_len     <= r_pend_len;
      r_bit_cnt <= {CNT_W{1'b0}};
    end else if ((r_state == S_SEND) && !w_last) begin
      r_shift   <= MSB_FIRST ? (r_shift << 1) : (r_shift >> 1);
      r_bit_cnt <= r_bit_cnt + CNT_W'(1);
    end else begin
      r_bit_cnt <= r_bit_cnt;
    end
  end

endmodule

// File: tb/tb_serial_out_stage_p.sv
// Directed bench for serial_out_stage_p: one MSB-first and one LSB-first instance
// sharing all inputs, checked with immediate assertions.
module tb_serial_out_stage_p;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [127:0] data_gray;
  logic [7:0]   vld_ch;
  logic [15:0]  data_count;
  logic         abort;

  logic         in_ready, crc_valid, busy, frame_done, err_frame;
  logic [7:0]   data_out, data_vld;
  logic         in_ready_l, crc_valid_l, busy_l, frame_done_l, err_frame_l;
  logic [7:0]   data_out_l, data_vld_l;

  int n_tests = 0;
  int n_fail  = 0;
  int vcnt, ones, dcnt;

  always #5 clk = ~clk;

  serial_out_stage_p u_msb (
    .clk_out16x(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .data_gray(data_gray), .vld_ch(vld_ch), .data_count(data_count), .abort(abort),
    .data_out(data_out), .data_vld(data_vld), .crc_valid(crc_valid), .busy(busy),
    .frame_done(frame_done), .err_frame(err_frame)
  );

  serial_out_stage_p #(.MSB_FIRST(1'b0)) u_lsb (
    .clk_out16x(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_l),
    .data_gray(data_gray), .vld_ch(vld_ch), .data_count(data_count), .abort(abort),
    .data_out(data_out_l), .data_vld(data_vld_l), .crc_valid(crc_valid_l), .busy(busy_l),
    .frame_done(frame_done_l), .err_frame(err_frame_l)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] want);
    n_tests++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [7:0] want_vld, input logic [7:0] want_out);
    chk({tag, "_vld"}, data_vld, want_vld);
    chk({tag, "_out"}, data_out, want_out);
  endtask

  // Present a frame for exactly one edge; returns just after that edge
  task automatic offer(input logic [127:0] d, input logic [7:0] ch, input logic [15:0] cnt);
    chk("offer_ready", in_ready, 1'b1);
    data_gray  = d;
    vld_ch     = ch;
    data_count = cnt;
    in_valid   = 1'b1;
    step();
    in_valid   = 1'b0;
  endtask

  initial begin
    logic [7:0] bits_a5;
    bits_a5    = 8'hA5;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    data_gray  = 128'h0;
    vld_ch     = 8'h00;
    data_count = 16'd0;
    abort      = 1'b0;
    #2;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_vld", data_vld, 8'h00);
    #10 rst_n = 1'b1;
    step();
    chk("idle_ready", in_ready, 1'b1);
    chk("idle_busy", busy, 1'b0);
    chk("idle_crc", crc_valid, 1'b0);
    chk("idle_done", frame_done, 1'b0);
    chk("idle_err", err_frame, 1'b0);
    chk_out("idle", 8'h00, 8'h00);

    // 1: 0xA5 on channel 2, MSB first
    offer(128'hA5 << 120, 8'h04, 16'd8);
    chk("t1_pend_ready", in_ready, 1'b0);
    chk("t1_pend_busy", busy, 1'b1);
    chk_out("t1_pend", 8'h00, 8'h00);
    step();
    for (int i = 0; i < 8; i++) begin
      chk_out("t1_bit", 8'h04, bits_a5[7-i] ? 8'h04 : 8'h00);
      chk("t1_crc", crc_valid, 1'b1);
      chk("t1_done_lo", frame_done, 1'b0);
      step();
    end
    chk_out("t1_end", 8'h00, 8'h00);
    chk("t1_done", frame_done, 1'b1);
    step();
    chk("t1_done_clr", frame_done, 1'b0);
    chk("t1_idle_busy", busy, 1'b0);

    // 2: A (1001, ch0) then B (101, ch7) back-to-back
    offer(128'h9 << 124, 8'h01, 16'd4);
    step();
    chk_out("t2_a0", 8'h01, 8'h01);
    offer(128'h5 << 125, 8'h80, 16'd3);
    chk_out("t2_a1", 8'h01, 8'h00);
    chk("t2_rdy1", in_ready, 1'b0);
    step();
    chk_out("t2_a2", 8'h01, 8'h00);
    chk("t2_rdy2", in_ready, 1'b0);
    step();
    chk_out("t2_a3", 8'h01, 8'h01);
    chk("t2_rdy3", in_ready, 1'b0);
    step();
    chk_out("t2_b0", 8'h80, 8'h80);
    chk("t2_done_a", frame_done, 1'b1);
    chk("t2_rdy4", in_ready, 1'b1);
    step();
    chk_out("t2_b1", 8'h80, 8'h00);
    chk("t2_done_lo", frame_done, 1'b0);
    step();
    chk_out("t2_b2", 8'h80, 8'h80);
    step();
    chk_out("t2_end", 8'h00, 8'h00);
    chk("t2_done_b", frame_done, 1'b1);
    step();

    // 3: invalid frames are dropped with an error pulse
    offer(128'hFF, 8'h06, 16'd4);
    chk("t3_err_2hot", err_frame, 1'b1);
    chk("t3_rdy_2hot", in_ready, 1'b1);
    chk("t3_busy_2hot", busy, 1'b0);
    chk_out("t3_2hot", 8'h00, 8'h00);
    offer(128'hFF, 8'h00, 16'd4);
    chk("t3_err_zero", err_frame, 1'b1);
    chk("t3_busy_zero", busy, 1'b0);
    offer(128'hFF, 8'h01, 16'd0);
    chk("t3_err_cnt0", err_frame, 1'b1);
    chk("t3_busy_cnt0", busy, 1'b0);
    step();
    chk("t3_err_clr", err_frame, 1'b0);
    chk_out("t3_quiet", 8'h00, 8'h00);

    // 4: oversize count is clamped to 128 bits
    offer((128'h1 << 127) | 128'h1, 8'h01, 16'd200);
    step();
    vcnt = 0; ones = 0; dcnt = 0;
    for (int i = 0; i < 200; i++) begin
      if (data_vld[0]) vcnt++;
      if (data_out[0]) ones++;
      if (frame_done) dcnt++;
      step();
    end
    chk("t4_valid_bits", vcnt, 128);
    chk("t4_ones", ones, 2);
    chk("t4_done_cnt", dcnt, 1);

    // 5: LSB-first instance sends 0,1,1,0,1 for 0x16
    offer(128'h16, 8'h02, 16'd5);
    step();
    chk("t5_b0", {data_vld_l, data_out_l}, {8'h02, 8'h00});
    step();
    chk("t5_b1", {data_vld_l, data_out_l}, {8'h02, 8'h02});
    step();
    chk("t5_b2", {data_vld_l, data_out_l}, {8'h02, 8'h02});
    step();
    chk("t5_b3", {data_vld_l, data_out_l}, {8'h02, 8'h00});
    step();
    chk("t5_b4", {data_vld_l, data_out_l}, {8'h02, 8'h02});
    step();
    chk("t5_end", {data_vld_l, data_out_l}, {8'h00, 8'h00});
    chk("t5_done", frame_done_l, 1'b1);
    step();

    // 6a: abort at bit 3 with a frame pending; a same-edge handshake is discarded
    offer(128'hFFFF << 112, 8'h08, 16'd16);
    step();
    offer(128'hF << 124, 8'h01, 16'd4);
    step();
    step();
    chk_out("t6_bit3", 8'h08, 8'h08);
    chk("t6_pend_rdy", in_ready, 1'b0);
    abort      = 1'b1;
    in_valid   = 1'b1;
    data_gray  = 128'hF << 124;
    vld_ch     = 8'h02;
    data_count = 16'd2;
    step();
    abort    = 1'b0;
    in_valid = 1'b0;
    chk_out("t6_abort", 8'h00, 8'h00);
    chk("t6_crc", crc_valid, 1'b0);
    chk("t6_done", frame_done, 1'b0);
    chk("t6_rdy", in_ready, 1'b1);
    chk("t6_busy", busy, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk_out("t6_after", 8'h00, 8'h00);
      chk("t6_after_done", frame_done, 1'b0);
    end

    // 6b: asynchronous reset mid-frame clears outputs at once
    offer(128'hFFFF << 112, 8'h10, 16'd16);
    step();
    step();
    chk_out("t6_pre_rst", 8'h10, 8'h10);
    #2 rst_n = 1'b0;
    #1;
    chk_out("t6_rst", 8'h00, 8'h00);
    chk("t6_rst_crc", crc_valid, 1'b0);
    chk("t6_rst_rdy", in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk_out("t6_post_rst", 8'h00, 8'h00);
    chk("t6_post_busy", busy, 1'b0);
    chk("t6_post_done", frame_done, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
